// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

   typedef enum logic {
      FETCH  = 1'b0,
      SQUASH = 1'b1
   } fetch_state_t;

   localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_1000;
   localparam logic [31:0] DEFAULT_EXC_VECTOR   = 32'h0000_2000;
   localparam logic [31:0] NOP_INSTR            = 32'h0000_0000;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry pc+instruction holding register used when decode stalls on a returning fetch.
module fetch_skid_buffer
   import fetch_pkg::*;
#(
   parameter int unsigned ADDRESS_SIZE = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    load,
   input  logic                    unload,
   input  logic                    clear,
   input  logic [ADDRESS_SIZE-1:0] load_pc,
   input  logic [31:0]             load_instr,
   output logic                    full,
   output logic [ADDRESS_SIZE-1:0] pc,
   output logic [31:0]             instr
);

   always_ff @(posedge clk) begin
      if (reset) begin
         full  <= 1'b0;
         pc    <= '0;
         instr <= NOP_INSTR;
      end else begin
         if (clear) begin
            full <= 1'b0;
         end else if (load) begin
            full  <= 1'b1;
            pc    <= load_pc;
            instr <= load_instr;
         end else if (unload) begin
            full <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/fetch_sequencer.sv
// Owns the architectural PC, drives the imem req/ack handshake and presents fetched
// instructions to decode, squashing outstanding work on branch or exception redirects.
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter int unsigned            ADDRESS_SIZE     = 32,
   parameter int unsigned            INSTRUCTION_SIZE = 4,
   parameter logic [ADDRESS_SIZE-1:0] RESET_VECTOR    = DEFAULT_RESET_VECTOR,
   parameter logic [ADDRESS_SIZE-1:0] EXC_VECTOR      = DEFAULT_EXC_VECTOR
) (
   input  logic                    clk,
   input  logic                    reset,
   output logic                    imem_req,
   output logic [ADDRESS_SIZE-1:0] imem_addr,
   input  logic                    imem_ack,
   input  logic [31:0]             imem_data,
   input  logic                    redirect_valid,
   input  logic [ADDRESS_SIZE-1:0] redirect_pc,
   input  logic                    exc_valid,
   input  logic                    stall,
   output logic                    if_valid,
   output logic [ADDRESS_SIZE-1:0] if_pc,
   output logic [31:0]             if_instr,
   output logic                    flush
);

   fetch_state_t state_q, state_d;
   logic [ADDRESS_SIZE-1:0] pc_q, pc_d;
   logic [ADDRESS_SIZE-1:0] addr_q;
   logic                    pending_q;
   logic                    if_valid_d;
   logic [ADDRESS_SIZE-1:0] if_pc_d;
   logic [31:0]             if_instr_d;
   logic                    flush_d;

   logic                    skid_load, skid_unload, skid_clear, skid_full;
   logic [ADDRESS_SIZE-1:0] skid_pc;
   logic [31:0]             skid_instr;

   logic                    redirect_any;
   logic [ADDRESS_SIZE-1:0] target;
   logic                    xfer;
   logic                    waiting;

   assign redirect_any = exc_valid || redirect_valid;
   assign target       = exc_valid ? EXC_VECTOR
                                   : (redirect_pc & ~ADDRESS_SIZE'(3));

   // An outstanding request keeps its captured address even after pc has been redirected.
   assign imem_req  = !reset && (pending_q || (state_q == FETCH && !skid_full));
   assign imem_addr = pending_q ? addr_q : pc_q;
   assign xfer      = imem_req && imem_ack;
   assign waiting   = imem_req && !imem_ack;

   fetch_skid_buffer #(
      .ADDRESS_SIZE (ADDRESS_SIZE)
   ) u_skid (
      .clk        (clk),
      .reset      (reset),
      .load       (skid_load),
      .unload     (skid_unload),
      .clear      (skid_clear),
      .load_pc    (pc_q),
      .load_instr (imem_data),
      .full       (skid_full),
      .pc         (skid_pc),
      .instr      (skid_instr)
   );

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      if_valid_d  = if_valid;
      if_pc_d     = if_pc;
      if_instr_d  = if_instr;
      flush_d     = 1'b0;
      skid_load   = 1'b0;
      skid_unload = 1'b0;
      skid_clear  = 1'b0;

      if (redirect_any) begin
         pc_d       = target;
         if_valid_d = 1'b0;
         skid_clear = 1'b1;
         flush_d    = 1'b1;
         state_d    = waiting ? SQUASH : FETCH;
      end else if (state_q == SQUASH) begin
         if (xfer) begin
            state_d = FETCH;
         end
      end else begin
         if (xfer) begin
            pc_d = pc_q + ADDRESS_SIZE'(INSTRUCTION_SIZE);
            if (!if_valid || !stall) begin
               if_valid_d = 1'b1;
               if_pc_d    = pc_q;
               if_instr_d = imem_data;
            end else begin
               skid_load = 1'b1;
            end
         end else if (if_valid && !stall) begin
            if (skid_full) begin
               if_pc_d     = skid_pc;
               if_instr_d  = skid_instr;
               skid_unload = 1'b1;
            end else begin
               if_valid_d = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= FETCH;
         pc_q      <= RESET_VECTOR;
         pending_q <= 1'b0;
         addr_q    <= '0;
         if_valid  <= 1'b0;
         if_pc     <= '0;
         if_instr  <= NOP_INSTR;
         flush     <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         pending_q <= waiting;
         if (waiting) begin
            addr_q <= imem_addr;
         end
         if_valid  <= if_valid_d;
         if_pc     <= if_pc_d;
         if_instr  <= if_instr_d;
         flush     <= flush_d;
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: handshake sequencing, stall/skid, redirects, wrap, reset.
module tb_fetch_sequencer;
   import fetch_pkg::*;

   localparam logic [31:0] DATA_KEY = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        exc_valid;
   logic        stall;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        flush;

   int unsigned checks = 0;
   int unsigned errors = 0;

   fetch_sequencer #(
      .ADDRESS_SIZE     (32),
      .INSTRUCTION_SIZE (4),
      .RESET_VECTOR     (32'h0000_1000),
      .EXC_VECTOR       (32'h0000_2000)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_data      (imem_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .exc_valid      (exc_valid),
      .stall          (stall),
      .if_valid       (if_valid),
      .if_pc          (if_pc),
      .if_instr       (if_instr),
      .flush          (flush)
   );

   always #5 clk = ~clk;

   // Memory model: each word is derived from its address so order errors are visible.
   assign imem_data = imem_addr ^ DATA_KEY;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input logic [31:0] pc);
      check_value({tag, "_valid"}, {31'b0, if_valid}, 32'd1);
      check_value({tag, "_pc"}, if_pc, pc);
      check_value({tag, "_instr"}, if_instr, pc ^ DATA_KEY);
   endtask

   initial begin
      reset = 1'b1; imem_ack = 1'b0; stall = 1'b0;
      redirect_valid = 1'b0; redirect_pc = '0; exc_valid = 1'b0;

      // Reset state
      tick;
      check_value("rst_req",   {31'b0, imem_req}, 32'd0);
      check_value("rst_valid", {31'b0, if_valid}, 32'd0);
      check_value("rst_pc",    if_pc, 32'd0);
      check_value("rst_instr", if_instr, 32'd0);
      check_value("rst_flush", {31'b0, flush}, 32'd0);
      check_value("rst_addr",  imem_addr, 32'h1000);

      // Zero-wait streaming
      reset = 1'b0; imem_ack = 1'b1; #1;
      check_value("t1_req0",  {31'b0, imem_req}, 32'd1);
      check_value("t1_addr0", imem_addr, 32'h1000);
      tick;
      check_out("t1_o0", 32'h1000);
      check_value("t1_addr1", imem_addr, 32'h1004);
      tick;
      check_out("t1_o1", 32'h1004);
      check_value("t1_addr2", imem_addr, 32'h1008);
      tick;
      check_out("t1_o2", 32'h1008);

      // Stall for three cycles with ack always high
      reset = 1'b1; stall = 1'b1; tick;
      reset = 1'b0; tick;
      check_out("t2_e1", 32'h1000);
      check_value("t2_e1_addr", imem_addr, 32'h1004);
      tick;
      check_out("t2_e2", 32'h1000);
      check_value("t2_e2_req", {31'b0, imem_req}, 32'd0);
      tick;
      check_out("t2_e3", 32'h1000);
      check_value("t2_e3_req", {31'b0, imem_req}, 32'd0);
      stall = 1'b0;
      tick;
      check_out("t2_e4", 32'h1004);
      check_value("t2_e4_addr", imem_addr, 32'h1008);
      tick;
      check_out("t2_e5", 32'h1008);

      // Redirect while a request is outstanding
      reset = 1'b1; tick;
      reset = 1'b0; tick; tick;
      check_value("t3_addr_pend", imem_addr, 32'h1008);
      imem_ack = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h2002;
      tick;
      check_value("t3_flush1", {31'b0, flush}, 32'd1);
      check_value("t3_valid1", {31'b0, if_valid}, 32'd0);
      check_value("t3_req1",   {31'b0, imem_req}, 32'd1);
      check_value("t3_addr1",  imem_addr, 32'h1008);
      redirect_valid = 1'b0;
      tick;
      check_value("t3_flush2", {31'b0, flush}, 32'd0);
      check_value("t3_addr2",  imem_addr, 32'h1008);
      imem_ack = 1'b1;
      tick;
      check_value("t3_discard", {31'b0, if_valid}, 32'd0);
      check_value("t3_addr3",   imem_addr, 32'h2000);
      imem_ack = 1'b0;
      tick;
      check_value("t3_hold_req",  {31'b0, imem_req}, 32'd1);
      check_value("t3_hold_addr", imem_addr, 32'h2000);
      imem_ack = 1'b1;
      tick;
      check_out("t3_tgt", 32'h2000);
      check_value("t3_addr4", imem_addr, 32'h2004);

      // Exception beats branch redirect; also coincides with ack and stall
      exc_valid = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h3000; stall = 1'b1;
      tick;
      check_value("t4_flush1", {31'b0, flush}, 32'd1);
      check_value("t4_valid",  {31'b0, if_valid}, 32'd0);
      check_value("t4_addr",   imem_addr, 32'h2000);
      exc_valid = 1'b0; redirect_valid = 1'b0; stall = 1'b0;
      tick;
      check_value("t4_flush2", {31'b0, flush}, 32'd0);
      check_out("t4_tgt", 32'h2000);

      // PC wrap at top of address space
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
      tick;
      check_value("t5_addr_top", imem_addr, 32'hFFFF_FFFC);
      redirect_valid = 1'b0;
      tick;
      check_out("t5_top", 32'hFFFF_FFFC);
      check_value("t5_wrap", imem_addr, 32'h0000_0000);

      // Reset while squashing
      imem_ack = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h4000;
      tick;
      check_value("t6_flush", {31'b0, flush}, 32'd1);
      check_value("t6_addr_sq", imem_addr, 32'h0000_0000);
      redirect_valid = 1'b0; reset = 1'b1; #1;
      check_value("t6_req_in_rst", {31'b0, imem_req}, 32'd0);
      tick;
      check_value("t6_req",   {31'b0, imem_req}, 32'd0);
      check_value("t6_valid", {31'b0, if_valid}, 32'd0);
      check_value("t6_pc",    imem_addr, 32'h1000);
      reset = 1'b0; #1;
      check_value("t6_req_rel",  {31'b0, imem_req}, 32'd1);
      check_value("t6_addr_rel", imem_addr, 32'h1000);
      imem_ack = 1'b1;
      tick;
      check_out("t6_first", 32'h1000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
